// File: rtl/c_fetch_aligner_if.sv
// Fetch-side and decode-side handshake bundle for c_fetch_aligner.
// C_ILLEGAL_EN adds the inst_illegal_o flag.
interface c_fetch_aligner_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned FETCH_W = 32
);
   logic               fetch_valid_i;
   logic               fetch_ready_o;
   logic [FETCH_W-1:0] fetch_data_i;
   logic               sel_for_branch;
   logic [XLEN-1:0]    branch_pc_i;
   logic               inst_valid_o;
   logic               inst_ready_i;
   logic [31:0]        inst_o;
   logic [XLEN-1:0]    inst_pc_o;
   logic               inst_compressed_o;
   logic               stall_pc;
`ifdef C_ILLEGAL_EN
   logic               inst_illegal_o;
`endif

   modport slave (
      input  fetch_valid_i, fetch_data_i, sel_for_branch, branch_pc_i, inst_ready_i,
      output fetch_ready_o, inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, stall_pc
`ifdef C_ILLEGAL_EN
      , output inst_illegal_o
`endif
   );

   modport master (
      output fetch_valid_i, fetch_data_i, sel_for_branch, branch_pc_i, inst_ready_i,
      input  fetch_ready_o, inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, stall_pc
`ifdef C_ILLEGAL_EN
      , input inst_illegal_o
`endif
   );
endinterface

// File: rtl/c_fetch_aligner.sv
// Halfword-queue instruction aligner between fetch and decode (RVC + 32-bit).
// Optional macro C_ILLEGAL_EN flags the all-zero compressed encoding.
module c_fetch_aligner #(
   parameter int unsigned    XLEN     = 32,
   parameter int unsigned    FETCH_W  = 32,
   parameter int unsigned    BUF_HW   = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   c_fetch_aligner_if.slave bus
);
   localparam int unsigned NHW    = FETCH_W / 16;
   localparam int unsigned PTR_W  = $clog2(BUF_HW);
   localparam int unsigned CNT_W  = $clog2(BUF_HW + 1);
   localparam int unsigned SKIP_W = $clog2(FETCH_W / 8) - 1;

   logic [15:0]       q_q [BUF_HW];
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [SKIP_W-1:0] skip_q, skip_d;

   logic [15:0]      h0, h1;
   logic             is32, valid, ready, push, pop;
   logic [CNT_W-1:0] n_push, n_pop;

   function automatic logic [PTR_W-1:0] wrap(input int v);
      return PTR_W'(v % int'(BUF_HW));
   endfunction

   assign h0     = q_q[head_q];
   assign h1     = q_q[wrap(int'(head_q) + 1)];
   assign is32   = (h0[1:0] == 2'b11);
   assign valid  = is32 ? (count_q >= CNT_W'(2)) : (count_q >= CNT_W'(1));
   // Registered count only: a same-cycle pop does not free space for this fetch.
   assign ready  = (count_q <= CNT_W'(BUF_HW - NHW));
   assign push   = bus.fetch_valid_i & ready & ~bus.sel_for_branch;
   assign pop    = valid & bus.inst_ready_i & ~bus.sel_for_branch;
   assign n_push = CNT_W'(NHW) - CNT_W'(skip_q);
   assign n_pop  = is32 ? CNT_W'(2) : CNT_W'(1);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      pc_d    = pc_q;
      skip_d  = skip_q;
      if (bus.sel_for_branch) begin
         // Flush by snapping head onto tail; the pointers stay consistent with count=0.
         head_d  = tail_q;
         count_d = '0;
         pc_d    = {bus.branch_pc_i[XLEN-1:1], 1'b0};
         skip_d  = bus.branch_pc_i[SKIP_W:1];
      end else begin
         if (pop) begin
            head_d = wrap(int'(head_q) + int'(n_pop));
            pc_d   = pc_q + (is32 ? XLEN'(4) : XLEN'(2));
         end
         if (push) begin
            tail_d = wrap(int'(tail_q) + int'(n_push));
            skip_d = '0;
         end
         count_d = count_q + (push ? n_push : '0) - (pop ? n_pop : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         pc_q    <= RESET_PC;
         skip_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         pc_q    <= pc_d;
         skip_q  <= skip_d;
      end
   end

   // Halfwords below the branch offset are dropped; the rest pack from tail upward.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int i = 0; i < int'(NHW); i++) begin
            if (i >= int'(skip_q)) begin
               q_q[wrap(int'(tail_q) + i - int'(skip_q))] <= bus.fetch_data_i[16*i +: 16];
            end
         end
      end
   end

   assign bus.fetch_ready_o     = ready;
   assign bus.stall_pc          = ~ready;
   assign bus.inst_valid_o      = valid;
   assign bus.inst_o            = !valid ? 32'h0000_0013 : (is32 ? {h1, h0} : {16'h0000, h0});
   assign bus.inst_pc_o         = pc_q;
   assign bus.inst_compressed_o = valid & ~is32;
`ifdef C_ILLEGAL_EN
   assign bus.inst_illegal_o    = valid & ~is32 & (h0 == 16'h0000);
`endif

   logic unused_branch_lsb;
   assign unused_branch_lsb = bus.branch_pc_i[0];
endmodule

// File: tb/tb_c_fetch_aligner.sv
// Self-checking bench for c_fetch_aligner: directed test-plan steps plus random traffic
// checked against a halfword-queue reference model.
module tb_c_fetch_aligner;
   localparam int unsigned XLEN    = 32;
   localparam int unsigned FETCH_W = 32;
   localparam int unsigned BUF_HW  = 4;
   localparam int unsigned NHW     = FETCH_W / 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   c_fetch_aligner_if #(.XLEN(XLEN), .FETCH_W(FETCH_W)) bus ();

   c_fetch_aligner #(.XLEN(XLEN), .FETCH_W(FETCH_W), .BUF_HW(BUF_HW), .RESET_PC(32'h0))
      dut (.clk(clk), .reset(reset), .bus(bus));

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model: plain halfword queue, PC and pending branch offset.
   logic [15:0] mq [$];
   logic [31:0] mpc;
   int          mskip;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic fv, input logic [31:0] fd,
                       input logic sel, input logic [31:0] br, input logic ir);
      int          n;
      logic        e_is32, e_valid, e_ready;
      logic [31:0] e_inst;
      @(negedge clk);
      reset              = rst;
      bus.fetch_valid_i  = fv;
      bus.fetch_data_i   = fd;
      bus.sel_for_branch = sel;
      bus.branch_pc_i    = br;
      bus.inst_ready_i   = ir;
      #1;
      n       = mq.size();
      e_ready = (n <= int'(BUF_HW - NHW));
      e_is32  = (n > 0) && (mq[0][1:0] == 2'b11);
      e_valid = e_is32 ? (n >= 2) : (n >= 1);
      e_inst  = 32'h0000_0013;
      if (e_valid) e_inst = e_is32 ? {mq[1], mq[0]} : {16'h0000, mq[0]};
      chk("fetch_ready", 64'(bus.fetch_ready_o), 64'(e_ready));
      chk("stall_pc", 64'(bus.stall_pc), 64'(!e_ready));
      chk("inst_valid", 64'(bus.inst_valid_o), 64'(e_valid));
      chk("inst", 64'(bus.inst_o), 64'(e_inst));
      chk("inst_pc", 64'(bus.inst_pc_o), 64'(mpc));
      chk("compressed", 64'(bus.inst_compressed_o), 64'(e_valid && !e_is32));
`ifdef C_ILLEGAL_EN
      chk("illegal", 64'(bus.inst_illegal_o),
          64'(e_valid && !e_is32 && mq[0] == 16'h0000));
`endif
      if (rst) begin
         mq.delete();
         mpc   = 32'h0;
         mskip = 0;
      end else if (sel) begin
         mq.delete();
         mpc   = {br[31:1], 1'b0};
         mskip = int'(br[1]);
      end else begin
         if (e_valid && ir) begin
            void'(mq.pop_front());
            if (e_is32) void'(mq.pop_front());
            mpc = mpc + (e_is32 ? 32'd4 : 32'd2);
         end
         if (fv && e_ready) begin
            for (int i = mskip; i < int'(NHW); i++) mq.push_back(fd[16*i +: 16]);
            mskip = 0;
         end
      end
   endtask

   initial begin
      reset              = 1'b1;
      bus.fetch_valid_i  = 1'b0;
      bus.fetch_data_i   = '0;
      bus.sel_for_branch = 1'b0;
      bus.branch_pc_i    = '0;
      bus.inst_ready_i   = 1'b0;
      mpc   = 32'h0;
      mskip = 0;
      repeat (2) @(posedge clk);

      // Reset state, then a single 32-bit NOP word.
      step(0, 1, 32'h0000_0013, 0, 0, 1);
      step(0, 1, 32'h4505_4501, 0, 0, 1);
      chk("nop_out", 64'(bus.inst_o), 64'h13);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);

      // Straddling 32-bit instruction with back-to-back fetches.
      step(0, 1, 32'h0093_4501, 0, 0, 1);
      step(0, 1, 32'h0000_0010, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("straddle_inst", 64'(bus.inst_o), 64'h0010_0093);
      step(0, 0, 0, 0, 0, 1);

      // Redirect into the middle of a word; bit 0 of the target is ignored.
      step(0, 1, 32'hdead_beef, 1, 32'h0000_0103, 1);
      step(0, 1, 32'h0513_0001, 0, 0, 1);
      chk("redirect_bubble", 64'(bus.inst_valid_o), 64'h0);
      step(0, 1, 32'h4501_0000, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("redirect_pc", 64'(bus.inst_pc_o), 64'h102);
      step(0, 0, 0, 0, 0, 1);

      // Backpressure: fill the queue, then drain and follow the PC sequence.
      for (int i = 0; i < 6; i++) step(0, 1, 32'h4505_4501 + 32'(i << 8), 0, 0, 0);
      chk("bp_stall", 64'(bus.stall_pc), 64'h1);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1);

      // All-zero word: two compressed outputs (illegal encoding when enabled).
      step(0, 1, 32'h0000_0000, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);

      // Random traffic, with occasional redirects and resets.
      for (int c = 0; c < 2000; c++) begin
         logic [31:0] d, b;
         d = $urandom();
         b = $urandom() & 32'h0000_fffe;
         b[0] = 1'(($urandom() & 1));
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), d,
              ($urandom_range(0, 39) == 0), b, ($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/c_fetch_aligner.md
Name: c_fetch_aligner

Overview:
- Parametrised successor to the single-instruction misalignment realigner.
- Sits between the instruction fetch stage and decode. Buffers fetched halfwords in a small queue and emits one aligned instruction per handshake, either 16-bit compressed or 32-bit.
- 32-bit instructions that straddle fetch words are emitted without a NOP bubble whenever both halves are buffered.
- Supports halfword-aligned branch targets, wider fetch words, and valid/ready flow control on both sides.

Parameters:
- XLEN, 32, width of all PC ports.
- FETCH_W, 32, fetch word width in bits; legal values 32 or 64. NHW = FETCH_W/16 halfwords per word.
- BUF_HW, 4, halfword queue depth; must be >= NHW+1.
- RESET_PC, 32'h0000_0000, value of inst_pc_o after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fetch_valid_i  in  1  fetch word valid
- fetch_ready_o  out  1  aligner accepts fetch word this cycle
- fetch_data_i  in  FETCH_W  fetch word; halfword 0 is the lowest address
- sel_for_branch  in  1  redirect/flush request
- branch_pc_i  in  XLEN  redirect target (halfword aligned)
- inst_valid_o  out  1  instruction output valid
- inst_ready_i  in  1  decode accepts instruction
- inst_o  out  32  instruction; compressed forms are zero-extended in [31:16]
- inst_pc_o  out  XLEN  PC of inst_o
- inst_compressed_o  out  1  inst_o is a 16-bit instruction
- stall_pc  out  1  equals ~fetch_ready_o (legacy fetch-stall hookup)

Behaviour:
- One clock (clk); reset synchronous, active-high. All state updates on posedge clk.
- Reset state:
  - count=0, queue contents don't-care, inst_pc=RESET_PC, skip=0.
  - Outputs: inst_valid_o=0, inst_o=32'h0000_0013, inst_compressed_o=0, fetch_ready_o=1, stall_pc=0.
- Queue: circular halfword FIFO, BUF_HW entries, head/tail pointers mod BUF_HW, count 0..BUF_HW.
- fetch_ready_o = (count <= BUF_HW-NHW). This uses registered count only; same-cycle dequeue is not credited.
- Fetch accept (fetch_valid_i & fetch_ready_o & ~sel_for_branch):
  - The upper NHW-skip halfwords are pushed in ascending address order.
  - skip then clears to 0.
- Output decode, combinational from head halfword h0 (h1 = next entry):
  - h0[1:0] != 2'b11: compressed. inst_valid_o = (count>=1), inst_o = {16'h0, h0}, inst_compressed_o=1.
  - h0[1:0] == 2'b11: 32-bit. inst_valid_o = (count>=2), inst_o = {h1, h0}, inst_compressed_o=0.
  - Whenever inst_valid_o=0, inst_o=32'h0000_0013 and inst_compressed_o=0.
- Output handshake (inst_valid_o & inst_ready_i & ~sel_for_branch):
  - Pop 1 halfword (compressed) or 2 (32-bit).
  - inst_pc += 2 or 4, modulo 2^XLEN.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped. Never overflows, given the ready rule.
- Redirect (sel_for_branch=1), highest priority:
  - Queue flushed (count=0) and inst_pc <= {branch_pc_i[XLEN-1:1], 1'b0}.
  - skip <= branch_pc_i[log2(FETCH_W/8)-1:1].
  - Any fetch word or output handshake in the same cycle is discarded.
  - inst_valid_o is 0 in the cycle after the redirect.
  - The next accepted fetch word is the one containing the aligned target word.
- branch_pc_i[0] is ignored.
- A 32-bit instruction whose upper half is not yet fetched holds inst_valid_o=0 until that half is buffered; no NOP is emitted as a valid instruction.
- Reset asserted mid-operation overrides redirect and handshakes; the reset state applies next cycle.
- Latency: a word accepted in cycle N is visible at the output in cycle N+1 (queue registered, output combinational).

Optional Feature:
- Macro C_ILLEGAL_EN.
- When defined:
  - Adds output port inst_illegal_o (1 bit).
  - inst_illegal_o is asserted when inst_valid_o & inst_compressed_o & (h0==16'h0000), the defined-illegal RVC encoding.
  - The instruction is still emitted and popped normally.
  - Reset value 0.
- When undefined: the port is absent and no extra logic is present.

Test Plan:
- Reset, then fetch 32'h0000_0013 at PC 0 -> next cycle inst_valid_o=1, inst_o=32'h0000_0013, inst_pc_o=0, compressed=0. stall_pc=0 throughout.
- Fetch 32'h4505_4501 (two c.li) -> two output cycles: inst_o=32'h0000_4501 at pc 0, then 32'h0000_4505 at pc 2, both compressed=1.
- Straddling instruction: fetch 32'h0093_4501, then 32'h0000_0010 -> c.li at pc 0, then inst_o=32'h0010_0093 at pc 2, compressed=0, with no invalid cycle between when fetches are back-to-back.
- Redirect with branch_pc_i=32'h0000_0102, then fetch word 32'h0513_0001 from 0x100 -> halfword 0x0001 dropped. First output is 32-bit with h0=0x0513, once its upper half 0x0000 arrives from the next fetch; inst_pc_o=0x102. inst_valid_o=0 in the redirect cycle+1.
- Backpressure: hold inst_ready_i=0 and fetch continuously -> count stops at BUF_HW, fetch_ready_o=0 and stall_pc=1 while count > BUF_HW-NHW. No halfword is lost after release (check the PC sequence).
- C_ILLEGAL_EN defined, fetch 32'h0000_0000 -> two compressed outputs with inst_illegal_o=1. Macro undefined: the design elaborates without the port.
